sub_accum_pipe: RTL and testbench
=================================

# sub_accum_pipe

Multi-channel, parametrised subtract-and-accumulate pipeline. Each accepted beat computes `a - b` and adds the signed difference into one of `NUM_CH` per-channel running accumulators. Results return through a valid/ready stream with full backpressure. The block is the sequential successor to the combinational subtractor in the datapath test harness: it adds widths, channels, handshaking and optional saturation.

## Interface
Parameters:
- `WIDTH`, default 8: operand width.
- `NUM_CH`, default 4: number of accumulator channels, ≥2.
- `ACC_W`, default `WIDTH+4`: signed accumulator width, must be > `WIDTH`.
- `CH_W`, default `$clog2(NUM_CH)`: channel index width. Derived; do not override.

Ports:
- `clk_h`  in  1  clock. All state changes on the rising edge.
- `rst_h`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_ch`  in  CH_W  target channel. Values ≥ `NUM_CH` select channel `NUM_CH-1`.
- `a`, `b`  in  WIDTH each  unsigned operands.
- `clr_h`  in  1  clear request for one accumulator.
- `clr_ch`  in  CH_W  channel to clear.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_ch`  out  CH_W  channel of the output beat.
- `out_diff`  out  WIDTH+1  `a - b` modulo 2^(WIDTH+1). MSB is the borrow/sign.
- `out_acc`  out  ACC_W  accumulator value after this beat's update.
- `out_sat`  out  1  the update saturated. Tied 0 when saturation is compiled out.

## Operation
- Two register stages: S1 captures the input; S2 holds the output.
- Stall control:
  - `en2 = !out_valid | out_ready`
  - `en1 = !s1_valid | en2`
  - `in_ready = en1`, combinational and registered-state only. It does not depend on `in_valid`.
- An input transfer occurs when `in_valid & in_ready`. S1 loads `a`, `b`, and the clamped channel.
- S1→S2 transfer occurs when `s1_valid & en2`:
  - diff = `{1'b0,a} - {1'b0,b}` in WIDTH+1 bits, which is exactly the signed difference.
  - `acc[ch] <= acc[ch] + sext(diff)`.
  - S2 loads `ch`, `diff`, and the new `acc[ch]`.
- Only the S1→S2 transfer touches the accumulators. Back-to-back beats to the same channel therefore chain correctly with no forwarding logic.
- Clear:
  - When `clr_h`, `acc[clr_ch] <= 0` at the edge.
  - If the same edge performs an S1→S2 update to the same channel, clear wins. That beat's `out_acc = 0`, `out_sat = 0`, and `out_diff` is unaffected.
  - Clearing a different channel does not interfere with the update.
- Beats are emitted in acceptance order. None are dropped or duplicated.

## Timing
- Reset: `acc[*]=0`, `s1_valid=0`, `out_valid=0`, `out_ch=0`, `out_diff=0`, `out_acc=0`, `out_sat=0`. `in_ready=1` in the first cycle after reset.
- `rst_h` asserted mid-stream discards S1 and S2 contents and zeroes all accumulators on that edge. Reset overrides clear and any transfer.
- Latency: a beat accepted at edge k gives `out_valid=1` after edge k+1 when the output is not stalled.
- Throughput: one beat per cycle while `out_ready=1`.
- While `out_valid & !out_ready`, S2 holds all outputs stable.
- Under a stall, S1 can still absorb one more beat; then `in_ready=0`.
- `in_ready` recovers in the cycle `out_ready` returns high.

## Configuration
- `SUB_ACC_SAT_EN` defined: the accumulator update saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. `out_sat=1` on any beat that clipped.
- Not defined: two's-complement wrap modulo 2^ACC_W, and `out_sat` is constant 0.

## Test plan
All scenarios use WIDTH=8, NUM_CH=4, ACC_W=12.
- Reset: hold `rst_h` 2 cycles with random inputs -> all outputs 0 and `in_ready=1` on the first cycle after release.
- Basic: ch0 `a=10,b=3`, then `a=3,b=10`, with `out_ready=1` -> `out_diff=0x007` with `out_acc=7`, then `out_diff=0x1F9` with `out_acc=0`. Each beat appears 2 cycles after acceptance.
- Backpressure: 4 beats (ch0..3, `a=1,b=0`) with `out_ready=0` for 5 cycles -> `in_ready` drops after 2 accepted. The held output stays stable. After release, all 4 emerge in order with `out_acc=1` each.
- Saturation: 9 beats to ch1 with `a=255,b=0`:
  - With `SUB_ACC_SAT_EN`: 8th beat gives `out_acc=2040`; 9th gives 2047 (0x7FF) with `out_sat=1`.
  - Without the macro: 9th beat gives 0x8F7 with `out_sat=0`.
- Clear collision: ch2 holds 5; a beat ch2 `a=4,b=1` transfers on the same edge as `clr_h`, `clr_ch=2` -> `out_acc=0`, `out_diff=0x003`. A following ch2 beat `a=2,b=0` gives `out_acc=2`.
- Reset mid-stream: assert `rst_h` while S1 and S2 are both valid and stalled -> both discarded. The next ch0 beat `a=9,b=4` gives `out_acc=5`.

Source files
------------

// File: rtl/sub_accum_pipe.sv
// Two-stage subtract-and-accumulate pipeline with NUM_CH running accumulators and valid/ready handshaking.
// Optional macro SUB_ACC_SAT_EN: saturate the accumulators instead of wrapping.
module sub_accum_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int ACC_W  = WIDTH + 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_h,
    input  logic [CH_W-1:0]  clr_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH:0]   out_diff,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_sat
);
    logic             en1, en2, take_in, xfer, clr_hit;
    logic [CH_W-1:0]  in_ch_clamped;
    logic [WIDTH:0]   diff;
    logic [ACC_W-1:0] cur_acc, new_acc;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [CH_W-1:0]  s1_ch_q, s1_ch_d;

    logic             out_valid_q, out_valid_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [WIDTH:0]   out_diff_q, out_diff_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] acc_d [NUM_CH];

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;
    assign take_in  = in_valid && en1;
    assign xfer     = s1_valid_q && en2;

    // Out-of-range channel indices fold onto the last channel.
    assign in_ch_clamped = ({1'b0, in_ch} >= (CH_W+1)'(NUM_CH)) ? CH_W'(NUM_CH - 1) : in_ch;

    // The zero-extended subtraction in WIDTH+1 bits is the exact signed difference.
    assign diff    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign cur_acc = acc_q[s1_ch_q];
    assign clr_hit = clr_h && (clr_ch == s1_ch_q);

`ifdef SUB_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           new_sat;
    logic           out_sat_q, out_sat_d;

    // One guard bit exposes overflow; clip toward the sign of the true sum.
    always_comb begin
        sum_wide = (ACC_W+1)'($signed(cur_acc)) + (ACC_W+1)'($signed(diff));
        new_sat  = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!new_sat) begin
            new_acc = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            new_acc = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            new_acc = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin
        out_sat_d = out_sat_q;
        if (xfer) begin
            out_sat_d = new_sat && !clr_hit;
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            out_sat_q <= 1'b0;
        end else begin
            out_sat_q <= out_sat_d;
        end
    end

    assign out_sat = out_sat_q;
`else
    assign new_acc = cur_acc + ACC_W'($signed(diff));
    assign out_sat = 1'b0;
`endif

    // A clear on the same edge as an update to that channel wins.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            if (xfer && (s1_ch_q == CH_W'(i))) begin
                acc_d[i] = new_acc;
            end
            if (clr_h && (clr_ch == CH_W'(i))) begin
                acc_d[i] = '0;
            end
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_ch_d     = s1_ch_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_diff_d  = out_diff_q;
        out_acc_d   = out_acc_q;
        if (en1) begin
            s1_valid_d = in_valid;
        end
        if (take_in) begin
            s1_a_d  = a;
            s1_b_d  = b;
            s1_ch_d = in_ch_clamped;
        end
        if (en2) begin
            out_valid_d = s1_valid_q;
        end
        if (xfer) begin
            out_ch_d   = s1_ch_q;
            out_diff_d = diff;
            out_acc_d  = clr_hit ? '0 : new_acc;
        end
    end

    always_ff @(posedge clk_h) begin
        if (rst_h) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_ch_q     <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_diff_q  <= '0;
            out_acc_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_ch_q     <= s1_ch_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_diff_q  <= out_diff_d;
            out_acc_q   <= out_acc_d;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_diff  = out_diff_q;
    assign out_acc   = out_acc_q;
endmodule

// File: tb/tb_sub_accum_pipe.sv
// Self-checking bench for sub_accum_pipe: vector table, directed corner sequences and a randomized
// phase scored against an arithmetic model (honours SUB_ACC_SAT_EN).
module tb_sub_accum_pipe;
    localparam int WIDTH   = 8;
    localparam int NUM_CH  = 4;
    localparam int ACC_W   = 12;
    localparam int CH_W    = 2;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));

    logic             clk_h = 1'b0;
    logic             rst_h = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CH_W-1:0]  in_ch = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             clr_h = 1'b0;
    logic [CH_W-1:0]  clr_ch = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CH_W-1:0]  out_ch;
    logic [WIDTH:0]   out_diff;
    logic [ACC_W-1:0] out_acc;
    logic             out_sat;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [WIDTH:0]   diff;
        logic [ACC_W-1:0] acc;
        logic             sat;
    } beat_t;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp_diff;
        logic [ACC_W-1:0] exp_acc;
    } vec_t;

    int    model_acc [NUM_CH];
    bit    model_on = 1'b0;
    beat_t exp_q [$];
    beat_t mon_e;
    vec_t  vecs [6];

    sub_accum_pipe #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .ACC_W(ACC_W)) dut (
        .clk_h(clk_h), .rst_h(rst_h), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .a(a), .b(b), .clr_h(clr_h), .clr_ch(clr_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_diff(out_diff), .out_acc(out_acc), .out_sat(out_sat)
    );

    always #5 clk_h = ~clk_h;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: plain integer running sums, clipped or wrapped at the accumulator range.
    function automatic beat_t model_beat(input int ch, input int av, input int bv);
        beat_t r;
        int d;
        int s;
        d = av - bv;
        s = model_acc[ch] + d;
        r.sat = 1'b0;
`ifdef SUB_ACC_SAT_EN
        if (s > ACC_MAX) begin
            s = ACC_MAX;
            r.sat = 1'b1;
        end else if (s < ACC_MIN) begin
            s = ACC_MIN;
            r.sat = 1'b1;
        end
`else
        if (s > ACC_MAX) s = s - (1 << ACC_W);
        else if (s < ACC_MIN) s = s + (1 << ACC_W);
`endif
        model_acc[ch] = s;
        r.ch   = CH_W'(ch);
        r.diff = d[WIDTH:0];
        r.acc  = s[ACC_W-1:0];
        return r;
    endfunction

    always @(negedge clk_h) begin
        if (model_on && !rst_h) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rand_unexpected_beat", 64'(out_valid), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rand_ch", 64'(out_ch), 64'(mon_e.ch));
                    checkOutput("rand_diff", 64'(out_diff), 64'(mon_e.diff));
                    checkOutput("rand_acc", 64'(out_acc), 64'(mon_e.acc));
                    checkOutput("rand_sat", 64'(out_sat), 64'(mon_e.sat));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat(int'(in_ch), int'(a), int'(b)));
            end
        end
    end

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic doReset();
        rst_h = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            in_ch     = CH_W'($urandom);
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            clr_h     = 1'($urandom);
            clr_ch    = CH_W'($urandom);
            out_ready = 1'($urandom);
            tick();
        end
        rst_h     = 1'b0;
        in_valid  = 1'b0;
        clr_h     = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NUM_CH; i++) model_acc[i] = 0;
    endtask

    // One beat into an empty pipeline, checking the two-edge latency and the result.
    task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] av,
                                 input logic [WIDTH-1:0] bv, input logic clr_en,
                                 input logic [CH_W-1:0] clr_c, input logic [WIDTH:0] exp_diff,
                                 input logic [ACC_W-1:0] exp_acc, input logic exp_sat,
                                 input string name);
        in_valid = 1'b1;
        in_ch    = ch;
        a        = av;
        b        = bv;
        @(negedge clk_h);
        checkOutput($sformatf("%s_in_ready", name), 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        clr_h    = clr_en;
        clr_ch   = clr_c;
        @(negedge clk_h);
        checkOutput($sformatf("%s_early_valid", name), 64'(out_valid), 64'(0));
        tick();
        clr_h = 1'b0;
        @(negedge clk_h);
        checkOutput($sformatf("%s_valid", name), 64'(out_valid), 64'(1));
        checkOutput($sformatf("%s_ch", name), 64'(out_ch), 64'(ch));
        checkOutput($sformatf("%s_diff", name), 64'(out_diff), 64'(exp_diff));
        checkOutput($sformatf("%s_acc", name), 64'(out_acc), 64'(exp_acc));
        checkOutput($sformatf("%s_sat", name), 64'(out_sat), 64'(exp_sat));
        tick();
    endtask

    task automatic backpressureTest();
        int sent = 0;
        int got  = 0;
        doReset();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            in_valid = (sent < 4);
            in_ch    = CH_W'(sent);
            a        = 8'd1;
            b        = 8'd0;
            @(negedge clk_h);
            if (cyc >= 2) begin
                checkOutput("bp_in_ready_low", 64'(in_ready), 64'(0));
                checkOutput("bp_hold_valid", 64'(out_valid), 64'(1));
                checkOutput("bp_hold_ch", 64'(out_ch), 64'(0));
                checkOutput("bp_hold_acc", 64'(out_acc), 64'(1));
                checkOutput("bp_hold_diff", 64'(out_diff), 64'(1));
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        checkOutput("bp_accepted_under_stall", 64'(sent), 64'(2));
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            in_valid = (sent < 4);
            in_ch    = CH_W'(sent);
            @(negedge clk_h);
            if (cyc == 0) checkOutput("bp_in_ready_recover", 64'(in_ready), 64'(1));
            if (out_valid && out_ready) begin
                checkOutput("bp_order_ch", 64'(out_ch), 64'(got));
                checkOutput("bp_out_acc", 64'(out_acc), 64'(1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("bp_beats_out", 64'(got), 64'(4));
    endtask

    task automatic saturationTest();
        int sent = 0;
        int got  = 0;
        doReset();
        for (int cyc = 0; cyc < 20 && got < 9; cyc++) begin
            in_valid = (sent < 9);
            in_ch    = 2'd1;
            a        = 8'd255;
            b        = 8'd0;
            @(negedge clk_h);
            if (out_valid && out_ready) begin
                if (got == 7) begin
                    checkOutput("sat_beat8_acc", 64'(out_acc), 64'(2040));
                    checkOutput("sat_beat8_sat", 64'(out_sat), 64'(0));
                end
                if (got == 8) begin
`ifdef SUB_ACC_SAT_EN
                    checkOutput("sat_beat9_acc", 64'(out_acc), 64'(12'h7FF));
                    checkOutput("sat_beat9_sat", 64'(out_sat), 64'(1));
`else
                    checkOutput("sat_beat9_acc", 64'(out_acc), 64'(12'h8F7));
                    checkOutput("sat_beat9_sat", 64'(out_sat), 64'(0));
`endif
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        checkOutput("sat_beats_out", 64'(got), 64'(9));
    endtask

    task automatic midResetTest();
        doReset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 2'd0;
        a         = 8'd1;
        b         = 8'd0;
        tick();
        tick();
        in_valid = 1'b0;
        @(negedge clk_h);
        checkOutput("mid_s2_full", 64'(out_valid), 64'(1));
        checkOutput("mid_s1_full", 64'(in_ready), 64'(0));
        tick();
        rst_h = 1'b1;
        tick();
        rst_h     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk_h);
        checkOutput("mid_s2_discard", 64'(out_valid), 64'(0));
        tick();
        @(negedge clk_h);
        checkOutput("mid_s1_discard", 64'(out_valid), 64'(0));
        tick();
        applyStimulus(2'd0, 8'd9, 8'd4, 1'b0, 2'd0, 9'h005, 12'd5, 1'b0, "mid_next");
    endtask

    task automatic randomTest();
        doReset();
        model_on = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ch     = CH_W'($urandom);
            a         = WIDTH'($urandom);
            b         = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        checkOutput("rand_drained", 64'(exp_q.size()), 64'(0));
        model_on = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ch: 2'd0, a: 8'd10,  b: 8'd3,   exp_diff: 9'h007, exp_acc: 12'd7};
        vecs[1] = '{ch: 2'd0, a: 8'd3,   b: 8'd10,  exp_diff: 9'h1F9, exp_acc: 12'd0};
        vecs[2] = '{ch: 2'd3, a: 8'd200, b: 8'd50,  exp_diff: 9'h096, exp_acc: 12'd150};
        vecs[3] = '{ch: 2'd1, a: 8'd0,   b: 8'd255, exp_diff: 9'h101, exp_acc: 12'hF01};
        vecs[4] = '{ch: 2'd1, a: 8'd255, b: 8'd0,   exp_diff: 9'h0FF, exp_acc: 12'd0};
        vecs[5] = '{ch: 2'd3, a: 8'd0,   b: 8'd1,   exp_diff: 9'h1FF, exp_acc: 12'd149};

        doReset();
        @(negedge clk_h);
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_out_ch", 64'(out_ch), 64'(0));
        checkOutput("rst_out_diff", 64'(out_diff), 64'(0));
        checkOutput("rst_out_acc", 64'(out_acc), 64'(0));
        checkOutput("rst_out_sat", 64'(out_sat), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        tick();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].a, vecs[i].b, 1'b0, 2'd0, vecs[i].exp_diff,
                          vecs[i].exp_acc, 1'b0, $sformatf("vec%0d", i));
        end

        backpressureTest();
        saturationTest();

        doReset();
        applyStimulus(2'd2, 8'd5, 8'd0, 1'b0, 2'd0, 9'h005, 12'd5, 1'b0, "clr_prep");
        applyStimulus(2'd2, 8'd4, 8'd1, 1'b1, 2'd2, 9'h003, 12'd0, 1'b0, "clr_collide");
        applyStimulus(2'd2, 8'd2, 8'd0, 1'b0, 2'd0, 9'h002, 12'd2, 1'b0, "clr_after");
        applyStimulus(2'd3, 8'd7, 8'd0, 1'b0, 2'd0, 9'h007, 12'd7, 1'b0, "clr_other_prep");
        applyStimulus(2'd1, 8'd1, 8'd0, 1'b1, 2'd3, 9'h001, 12'd1, 1'b0, "clr_other_upd");
        applyStimulus(2'd3, 8'd0, 8'd0, 1'b0, 2'd0, 9'h000, 12'd0, 1'b0, "clr_other_done");

        midResetTest();
        randomTest();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
